// File: rtl/sram_if_pkg.sv
// sram_if_pkg: state encoding, timing defaults and request record shared by the SRAM controller.
package sram_if_pkg;
  localparam int RD_WAIT_DEF  = 1;
  localparam int WR_PULSE_DEF = 2;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ACT   = 3'd1;
  localparam logic [2:0] S_RD_CAP   = 3'd2;
  localparam logic [2:0] S_WR_SETUP = 3'd3;
  localparam logic [2:0] S_WR_PULSE = 3'd4;
  localparam logic [2:0] S_WR_HOLD  = 3'd5;
  typedef struct packed {
    logic        wr;
    logic [17:0] addr;
    logic [15:0] data;
  } req_t;
endpackage

// File: rtl/sram_req_edge.sv
// sram_req_edge: samples the bus requests, detects their rising edge with write priority
// and keeps a single pending request for service once the access engine frees up.
module sram_req_edge
  import sram_if_pkg::*;
(
  input  logic        CLK0,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [17:0] address,
  input  logic [15:0] data_write,
  input  logic        idle_i,
  input  logic        free_i,
  output logic        go_o,
  output req_t        go_req_o
);
  logic rd_s_q, wr_s_q, hist_q, pend_q, pend_d, rise, load;
  req_t pend_req_q, cur_req;
  assign rise = (rd_s_q | wr_s_q) & ~hist_q;
  assign cur_req = req_t'({wr_s_q, address, data_write});
  // Fresh edges start only from IDLE; a pending request also launches from a finishing state.
  assign load = rise & ~pend_q & ~idle_i;
  assign pend_d = load | (pend_q & ~free_i);
  assign go_o = (free_i & pend_q) | (idle_i & rise & ~pend_q);
  assign go_req_o = pend_q ? pend_req_q : cur_req;
  always_ff @(posedge CLK0 or negedge reset_n) begin
    if (!reset_n) begin
      rd_s_q     <= 1'b0;
      wr_s_q     <= 1'b0;
      hist_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_req_q <= '0;
    end else begin
      rd_s_q <= rd_req;
      wr_s_q <= wr_req;
      hist_q <= rd_s_q | wr_s_q;
      pend_q <= pend_d;
      if (load) pend_req_q <= cur_req;
    end
  end
endmodule

// File: rtl/sram_if_ctrl.sv
// sram_if_ctrl: asynchronous-SRAM access engine; sequences CS_n/OE_n/WE_n for single-word
// reads and writes with every pin driven straight from a register.
module sram_if_ctrl
  import sram_if_pkg::*;
#(
  parameter int RD_WAIT  = RD_WAIT_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF
) (
  input  logic        CLK0,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [17:0] address,
  input  logic [15:0] data_write,
  output logic [15:0] data_read,
  output logic        ready,
  output logic [17:0] address_pins,
  output logic [15:0] data_pins_out,
  input  logic [15:0] data_pins_in,
  output logic        data_pins_out_en,
  output logic        CS_n,
  output logic        OE_n,
  output logic        WE_n
);
  logic [2:0] state_q, state_d, cnt_q, cnt_d, start_s;
  logic       go, idle, free;
  req_t       go_req;
  assign idle = state_q == S_IDLE;
  assign free = idle | (state_q == S_RD_CAP) | (state_q == S_WR_HOLD);
  sram_req_edge u_edge (
    .CLK0       (CLK0),
    .reset_n    (reset_n),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .address    (address),
    .data_write (data_write),
    .idle_i     (idle),
    .free_i     (free),
    .go_o       (go),
    .go_req_o   (go_req)
  );
  assign start_s = !go ? S_IDLE : go_req.wr ? S_WR_SETUP : S_RD_ACT;
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE, S_RD_CAP, S_WR_HOLD: state_d = start_s;
      S_RD_ACT:   state_d = cnt_q == 3'(RD_WAIT - 1) ? S_RD_CAP : S_RD_ACT;
      S_WR_SETUP: state_d = S_WR_PULSE;
      S_WR_PULSE: state_d = cnt_q == 3'(WR_PULSE - 1) ? S_WR_HOLD : S_WR_PULSE;
      default:    state_d = S_IDLE;
    endcase
  end
  assign cnt_d = state_d == state_q ? cnt_q + 3'd1 : 3'd0;
  // Strobes are decoded from the next state so they change on the same edge as the FSM.
  always_ff @(posedge CLK0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= 3'd0;
      CS_n             <= 1'b1;
      OE_n             <= 1'b1;
      WE_n             <= 1'b1;
      data_pins_out_en <= 1'b0;
      ready            <= 1'b0;
      address_pins     <= '0;
      data_pins_out    <= '0;
      data_read        <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      CS_n             <= state_d == S_IDLE;
      OE_n             <= !(state_d inside {S_RD_ACT, S_RD_CAP});
      WE_n             <= state_d != S_WR_PULSE;
      data_pins_out_en <= state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
      ready            <= state_d == S_IDLE;
      if (go) address_pins <= go_req.addr;
      if (go && go_req.wr) data_pins_out <= go_req.data;
      if (state_q == S_RD_CAP) data_read <= data_pins_in;
    end
  end
endmodule

// File: tb/tb_sram_if_ctrl.sv
// tb_sram_if_ctrl: directed stimulus with a scoreboard queue; a negedge monitor pops one
// expected access each time the DUT finishes a read or a write.
module tb_sram_if_ctrl;
  logic        CLK0 = 1'b0, reset_n = 1'b1, rd_req = 1'b0, wr_req = 1'b0;
  logic [17:0] address = '0, address_pins;
  logic [15:0] data_write = '0, data_read, data_pins_out, data_pins_in;
  logic        ready, data_pins_out_en, CS_n, OE_n, WE_n;
  int          checks = 0, failures = 0, cyc = 0;
  logic [15:0] mem [256];
  typedef struct {
    bit          wr;
    logic [17:0] addr;
    logic [15:0] data;
    int          start;
    int          lat;
    bit          rdy;
  } exp_t;
  exp_t q[$];

  sram_if_ctrl dut (
    .CLK0             (CLK0),
    .reset_n          (reset_n),
    .rd_req           (rd_req),
    .wr_req           (wr_req),
    .address          (address),
    .data_write       (data_write),
    .data_read        (data_read),
    .ready            (ready),
    .address_pins     (address_pins),
    .data_pins_out    (data_pins_out),
    .data_pins_in     (data_pins_in),
    .data_pins_out_en (data_pins_out_en),
    .CS_n             (CS_n),
    .OE_n             (OE_n),
    .WE_n             (WE_n)
  );

  always #5 CLK0 = ~CLK0;
  always @(posedge CLK0) cyc <= cyc + 1;

  // SRAM model, indexed by the low address byte.
  always @(posedge CLK0)
    if (!reset_n) begin
      mem[8'h23] <= 16'hBEEF;
      mem[8'h01] <= 16'hCAFE;
    end else if (!CS_n && !WE_n) mem[address_pins[7:0]] <= data_pins_out;
  assign data_pins_in = (!CS_n && !OE_n) ? mem[address_pins[7:0]] : 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic        prev_oe = 1'b1, prev_en = 1'b0, ovl = 1'b0, a_bad = 1'b0, wdone, rdone;
  int          oe_cnt = 0, we_cnt = 0, en_cnt = 0;
  logic [17:0] a_seen = '0;
  logic [15:0] d_seen = '0;
  exp_t        e;
  always @(negedge CLK0) begin
    if (!reset_n) begin
      prev_oe = 1'b1; prev_en = 1'b0; ovl = 1'b0; a_bad = 1'b0;
      oe_cnt = 0; we_cnt = 0; en_cnt = 0;
    end else begin
      wdone = prev_en && !data_pins_out_en;
      rdone = !prev_oe && OE_n;
      if (wdone || rdone) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_op actual=%s required=none", wdone ? "write" : "read");
        end else begin
          e = q.pop_front();
          chk("kind", wdone, e.wr);
          chk("addr", a_seen, e.addr);
          chk("addr_stable", a_bad, 0);
          chk(wdone ? "wr_data" : "rd_data", wdone ? d_seen : data_read, e.data);
          chk("latency", cyc - e.start, e.lat);
          chk("ready_at_done", ready, e.rdy);
          chk("oe_we_overlap", ovl, 0);
          chk(wdone ? "we_low_cycles" : "oe_low_cycles", wdone ? we_cnt : oe_cnt, wdone ? 2 : 2);
          if (wdone) chk("en_high_cycles", en_cnt, 4);
        end
        oe_cnt = 0; we_cnt = 0; en_cnt = 0; a_bad = 1'b0; ovl = 1'b0;
      end
      if ((!OE_n && prev_oe) || (data_pins_out_en && !prev_en)) begin
        a_seen = address_pins;
        d_seen = data_pins_out;
      end else if ((!OE_n || data_pins_out_en) && address_pins !== a_seen) a_bad = 1'b1;
      if (!OE_n && !WE_n) ovl = 1'b1;
      oe_cnt += int'(!OE_n);
      we_cnt += int'(!WE_n);
      en_cnt += int'(data_pins_out_en);
      prev_oe = OE_n;
      prev_en = data_pins_out_en;
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [17:0] a, input logic [15:0] d,
                       output int s);
    @(negedge CLK0);
    rd_req = rd; wr_req = wr; address = a; data_write = d;
    @(posedge CLK0);
    #1 s = cyc;
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic expect_op(input bit wr, input logic [17:0] a, input logic [15:0] d,
                           input int s, input int lat, input bit rdy);
    exp_t x;
    x.wr = wr; x.addr = a; x.data = d; x.start = s; x.lat = lat; x.rdy = rdy;
    q.push_back(x);
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge CLK0);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    @(posedge CLK0);
  endtask

  initial begin
    int s, w;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_cs_n", CS_n, 1);
    chk("rst_oe_n", OE_n, 1);
    chk("rst_we_n", WE_n, 1);
    chk("rst_out_en", data_pins_out_en, 0);
    chk("rst_addr_pins", address_pins, 0);
    chk("rst_data_out", data_pins_out, 0);
    chk("rst_data_read", data_read, 0);
    chk("rst_ready", ready, 0);
    repeat (2) @(posedge CLK0);
    #2 reset_n = 1'b1;
    @(posedge CLK0);
    #1 chk("ready_after_reset", ready, 1);
    issue(1, 0, 18'h00123, 16'h0, s);
    expect_op(0, 18'h00123, 16'hBEEF, s, 3, 1);
    @(posedge CLK0);
    #1 chk("ready_fall", ready, 0);
    drain();
    issue(0, 1, 18'h3FFFF, 16'hA55A, s);
    expect_op(1, 18'h3FFFF, 16'hA55A, s, 5, 1);
    drain();
    chk("data_read_hold", data_read, 16'hBEEF);
    issue(1, 0, 18'h3FFFF, 16'h0, s);
    expect_op(0, 18'h3FFFF, 16'hA55A, s, 3, 1);
    drain();
    issue(1, 1, 18'h00010, 16'h1234, s);
    expect_op(1, 18'h00010, 16'h1234, s, 5, 1);
    drain();
    issue(1, 0, 18'h00010, 16'h0, s);
    expect_op(0, 18'h00010, 16'h1234, s, 3, 1);
    drain();
    // Write, then a read edge while busy (pending), then a third edge that must be dropped.
    issue(0, 1, 18'h00000, 16'h0F0F, w);
    expect_op(1, 18'h00000, 16'h0F0F, w, 5, 0);
    @(posedge CLK0);
    issue(1, 0, 18'h00001, 16'h0, s);
    expect_op(0, 18'h00001, 16'hCAFE, w, 7, 1);
    @(posedge CLK0);
    issue(1, 0, 18'h00003, 16'h0, s);
    drain();
    repeat (8) @(posedge CLK0);
    #1 chk("idle_after_pending", ready, 1);
    issue(0, 1, 18'h00020, 16'h7777, s);
    @(posedge CLK0);
    @(posedge CLK0);
    #2 chk("we_low_before_rst", WE_n, 0);
    reset_n = 1'b0;
    #1;
    chk("abort_we_n", WE_n, 1);
    chk("abort_out_en", data_pins_out_en, 0);
    chk("abort_cs_n", CS_n, 1);
    chk("abort_ready", ready, 0);
    chk("abort_addr_pins", address_pins, 0);
    @(negedge CLK0);
    #2 reset_n = 1'b1;
    @(posedge CLK0);
    #1 chk("ready_after_abort", ready, 1);
    repeat (4) @(posedge CLK0);
    #1 chk("final_queue_empty", q.size(), 0);
    chk("final_cs_n", CS_n, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_if_ctrl.md
SRAM_IF_CTRL -- requirements
Module: sram_if_ctrl

Interface
REQ-001 Parameter RD_WAIT, default 1: number of CLK0 cycles OE_n/CS_n are held low before read data is captured (range 1..7).
REQ-002 Parameter WR_PULSE, default 2: number of CLK0 cycles WE_n is held low (range 1..7).
REQ-003 CLK0  in  1  controller clock; all state and outputs update on the rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rd_req  in  1  level read request from the SoC bus, asynchronous to CLK0 phase but slower.
REQ-006 wr_req  in  1  level write request from the SoC bus.
REQ-007 address  in  18  word address of the access.
REQ-008 data_write  in  16  write data.
REQ-009 data_read  out  16  last captured read word.
REQ-010 ready  out  1  high when idle with nothing pending.
REQ-011 address_pins  out  18  SRAM address pins.
REQ-012 data_pins_out  out  16  SRAM data pins, output path.
REQ-013 data_pins_in  in  16  SRAM data pins, input path.
REQ-014 data_pins_out_en  out  1  data pin output-buffer enable.
REQ-015 CS_n, OE_n, WE_n  out  1 each  active-low SRAM strobes.

Function
REQ-016 All outputs shall be registered; no strobe shall be combinationally derived.
REQ-017 A request shall start on the CLK0 cycle where (rd_req|wr_req) is high and was low on the previous cycle (rising edge detect).
REQ-018 If both requests rise together, the write shall win; the read shall be dropped.
REQ-019 address and data_write shall be latched on the start cycle and held on the pins for the whole access.
REQ-020 A request edge arriving while busy shall set a single pending flag with its type and address; it shall be serviced immediately after return to IDLE; further edges while pending is set shall be dropped.
REQ-021 States: IDLE, RD_ACT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-022 Read: IDLE -> RD_ACT (CS_n=0, OE_n=0) for RD_WAIT cycles -> RD_CAP (data_pins_in captured into data_read, CS_n/OE_n still low) -> IDLE.
REQ-023 Write: IDLE -> WR_SETUP (CS_n=0, data driven, WE_n=1) 1 cycle -> WR_PULSE (WE_n=0) WR_PULSE cycles -> WR_HOLD (WE_n=1, data and address still driven) 1 cycle -> IDLE.
REQ-024 data_pins_out_en shall be high only in WR_SETUP, WR_PULSE and WR_HOLD; OE_n and WE_n shall never both be low.
REQ-025 ready shall fall on the cycle after the start edge and rise on the cycle IDLE is re-entered with no pending request.
REQ-026 With defaults, a read shall complete 3 cycles after the start edge and a write 5 cycles after it.
REQ-027 In IDLE: CS_n=OE_n=WE_n=1, data_pins_out_en=0; address_pins hold the last value.
REQ-028 data_read shall change only in RD_CAP.

Reset
REQ-029 On reset_n low, asynchronously: state=IDLE, pending=0, edge history=0, CS_n=OE_n=WE_n=1, data_pins_out_en=0, address_pins=0, data_pins_out=0, data_read=0, ready=0.
REQ-030 ready shall rise on the first CLK0 edge after reset_n deasserts.
REQ-031 Reset mid-access shall abort immediately; no partial write completion is required.

Structure
REQ-032 Package sram_if_pkg shall hold the state enumeration and the RD_WAIT/WR_PULSE defaults.
REQ-033 One sub-module, sram_req_edge, shall implement the edge detect, write priority and pending flag.

Verification
REQ-034 Read 18'h00123 with model word 16'hBEEF -> OE_n low 2 cycles, data_read=16'hBEEF and ready high 3 cycles after the start edge.
REQ-035 Write 16'hA55A to 18'h3FFFF -> WE_n low exactly 2 cycles, data_pins_out_en high 4 cycles, readback gives 16'hA55A.
REQ-036 rd_req and wr_req rise on the same cycle, address 18'h00010, data 16'h1234 -> only the write occurs.
REQ-037 Read edge at 18'h00001 during a write to 18'h00000 -> read starts on the cycle after WR_HOLD; a third edge during the write is dropped.
REQ-038 reset_n pulsed low during WR_PULSE -> WE_n=1, data_pins_out_en=0 within the same cycle; ready=1 on the first edge after release.
